// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for asyn_fifo (rclk domain only).
// Pops words through rinc/rempty/read_data and presents them on a
// valid/ready stream through a 2-entry (head + skid) buffer. The stream is
// framed with out_last every FRAME_LEN beats, and rd_count counts beats
// delivered to the downstream side. flush drops buffered words and drains
// the FIFO.
//
// Stream handshake: a beat transfers on a rising rclk edge when
// out_valid && out_ready. While out_valid=1 && out_ready=0, out_data and
// out_last hold stable. out_valid never depends on out_ready, and rinc
// depends only on registered occupancy, rempty, flush and rrst. out_ready
// therefore has no combinational path to rinc.
module fifo_rd_stream #(
  parameter int DSIZE     = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] read_data,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] rd_count
);

  localparam int               BEAT_W    = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Buffer state: occ counts valid entries (0..2). The head entry is the
  // one presented downstream; skid holds the word popped behind it.
  logic [1:0]        occ, occ_nxt;
  logic [DSIZE-1:0]  head, head_nxt;
  logic [DSIZE-1:0]  skid, skid_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [CNT_W-1:0]  count, count_nxt;

  logic pop;
  logic hs;

  // Pop whenever the FIFO has data and there is room (or we are draining).
  assign rinc      = !rrst && !rempty && (flush || (occ != 2'd2));
  // A flushing pop is dropped; only normal pops enter the buffer.
  assign pop       = rinc && !flush;
  assign out_valid = (occ != 2'd0);
  assign hs        = out_valid && out_ready;
  assign out_data  = head;
  assign out_last  = out_valid && (beat == LAST_BEAT);
  assign rd_count  = count;

  // Next-state for buffer, framing and delivered-word count.
  always_comb begin
    occ_nxt   = occ;
    head_nxt  = head;
    skid_nxt  = skid;
    beat_nxt  = beat;
    count_nxt = count;

    // A handshake completes even in a flush cycle, so it always counts.
    if (hs) begin
      count_nxt = count + CNT_ONE;
      beat_nxt  = (beat == LAST_BEAT) ? '0 : beat + BEAT_ONE;
    end

    if (flush) begin
      occ_nxt  = 2'd0;
      beat_nxt = '0;
    end else begin
      case ({pop, hs})
        2'b10: begin
          // Fill: first word lands in head, second waits in skid.
          occ_nxt = occ + 2'd1;
          if (occ == 2'd0) head_nxt = read_data;
          else             skid_nxt = read_data;
        end
        2'b01: begin
          // Drain: the skid word (if any) moves up to head.
          occ_nxt = occ - 2'd1;
          if (occ == 2'd2) head_nxt = skid;
        end
        2'b11: begin
          // Pop and handshake together only happen at occ=1 (occ=2 blocks
          // pops, occ=0 has nothing to hand over): new word replaces head.
          head_nxt = read_data;
        end
        default: ;
      endcase
    end
  end

  // State registers, asynchronously cleared by rrst.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ   <= 2'd0;
      head  <= '0;
      skid  <= '0;
      beat  <= '0;
      count <= '0;
    end else begin
      occ   <= occ_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
      beat  <= beat_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. Two instances share all inputs: u_dut with
// FRAME_LEN=4 and u_dut1 with FRAME_LEN=1. The asyn_fifo is represented by a
// queue; the stream side is predicted by a queue-based model of the words
// popped but not yet delivered.
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int CNT_W = 16;
  localparam int FL    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             rclk;
  logic             rrst;
  logic [DSIZE-1:0] read_data;
  logic             rempty;
  logic             flush;
  logic             out_ready;

  logic             rinc, rinc1;
  logic [DSIZE-1:0] out_data, out_data1;
  logic             out_valid, out_valid1;
  logic             out_last, out_last1;
  logic [CNT_W-1:0] rd_count, rd_count1;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  fifo_rd_stream #(.DSIZE(DSIZE), .FRAME_LEN(FL), .CNT_W(CNT_W)) u_dut (
    .rclk(rclk), .rrst(rrst), .read_data(read_data), .rempty(rempty),
    .rinc(rinc), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .rd_count(rd_count)
  );

  fifo_rd_stream #(.DSIZE(DSIZE), .FRAME_LEN(1), .CNT_W(CNT_W)) u_dut1 (
    .rclk(rclk), .rrst(rrst), .read_data(read_data), .rempty(rempty),
    .rinc(rinc1), .flush(flush), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1), .rd_count(rd_count1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] fifo_q[$];   // contents of the upstream FIFO
  logic [DSIZE-1:0] exp_q[$];    // words popped, not yet delivered
  int               m_beat;
  int               m_cnt;
  int               dut_pops;
  int               dut_lasts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    exp_q.delete();
    fifo_q.delete();
    m_beat = 0;
    m_cnt  = 0;
  endtask

  // Called at a negedge. Async reset must clear outputs immediately.
  task automatic do_reset();
    rrst = 1'b1;
    flush = 1'b0;
    #1;
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {16'd0, rd_count}, 32'd0);
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    model_clear();
    dut_pops  = 0;
    dut_lasts = 0;
  endtask

  // One cycle against the reference model, starting at a negedge with
  // out_ready/flush already set.
  task automatic tick();
    logic             e_rinc, e_valid, e_last, e_hs;
    logic [DSIZE-1:0] e_data;
    rempty    = (fifo_q.size() == 0);
    read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    e_rinc  = !rempty && (flush || exp_q.size() < 2);
    e_valid = (exp_q.size() != 0);
    e_data  = e_valid ? exp_q[0] : '0;
    e_last  = e_valid && (m_beat == FL - 1);
    chk("rinc", {31'd0, rinc}, {31'd0, e_rinc});
    chk("rinc1", {31'd0, rinc1}, {31'd0, e_rinc});
    chk("valid", {31'd0, out_valid}, {31'd0, e_valid});
    if (e_valid) begin
      chk("data", {24'd0, out_data}, {24'd0, e_data});
      chk("data1", {24'd0, out_data1}, {24'd0, e_data});
    end
    chk("last", {31'd0, out_last}, {31'd0, e_last});
    chk("last1", {31'd0, out_last1}, {31'd0, e_valid});
    chk("count", {16'd0, rd_count}, m_cnt & 32'hFFFF);
    chk("count1", {16'd0, rd_count1}, m_cnt & 32'hFFFF);
    if (rinc) dut_pops++;
    if (out_valid && out_ready && out_last) dut_lasts++;
    e_hs = e_valid && out_ready;
    @(posedge rclk);
    if (e_hs) begin
      void'(exp_q.pop_front());
      m_cnt++;
      m_beat = (m_beat + 1) % FL;
    end
    if (flush) begin
      exp_q.delete();
      m_beat = 0;
    end else if (e_rinc) begin
      exp_q.push_back(read_data);
    end
    if (e_rinc) void'(fifo_q.pop_front());
    @(negedge rclk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_words(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(DSIZE'(base + i));
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic             rrst;
    logic             rempty;
    logic [DSIZE-1:0] rd;
    logic             rdy;
    logic             fl;
    logic             e_rinc;
    logic             e_valid;
    logic [DSIZE-1:0] e_data;
    logic             e_last;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    rrst      = 1'b1;
    rempty    = 1'b0;
    read_data = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_clear();
    dut_pops  = 0;
    dut_lasts = 0;

    // Reset with data available, then a single word arriving while idle.
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
    vecs[5] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 16'd1};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

    @(negedge rclk);
    for (int i = 0; i < 8; i++) begin
      rrst      = vecs[i].rrst;
      rempty    = vecs[i].rempty;
      read_data = vecs[i].rd;
      out_ready = vecs[i].rdy;
      flush     = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_rinc", i), {31'd0, rinc}, {31'd0, vecs[i].e_rinc});
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_data});
      chk($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].e_last});
      chk($sformatf("vec%0d_last1", i), {31'd0, out_last1}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_count", i), {16'd0, rd_count}, {16'd0, vecs[i].e_cnt});
      @(posedge rclk);
      @(negedge rclk);
    end

    // Stream: 20 words at full rate.
    do_reset();
    out_ready = 1'b1;
    load_words(20, 0);
    run(24);
    chk("stream_count", {16'd0, rd_count}, 32'd20);
    chk("stream_pops", dut_pops, 32'd20);

    // Backpressure mid-stream, then resume.
    do_reset();
    load_words(20, 8'h40);
    out_ready = 1'b1;
    run(4);
    out_ready = 1'b0;
    run(5);
    out_ready = 1'b1;
    run(24);
    chk("bp_count", {16'd0, rd_count}, 32'd20);

    // Framing: 10 words with FRAME_LEN=4 -> two last beats (beats 4 and 8).
    do_reset();
    load_words(10, 8'h80);
    out_ready = 1'b1;
    run(14);
    chk("frame_lasts", dut_lasts, 32'd2);
    chk("frame_count", {16'd0, rd_count}, 32'd10);

    // Flush with the buffer full and words left in the FIFO.
    do_reset();
    load_words(6, 8'hC0);
    out_ready = 1'b0;
    run(3);
    flush = 1'b1;
    run(8);
    flush = 1'b0;
    chk("flush_drained", fifo_q.size(), 32'd0);
    chk("flush_pops", dut_pops, 32'd6);
    run(1);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_count", {16'd0, rd_count}, 32'd0);
    // Beat counter restarted: the 4th word after the flush is a last beat.
    load_words(4, 8'hD0);
    out_ready = 1'b1;
    dut_lasts = 0;
    run(7);
    chk("flush_beat", dut_lasts, 32'd1);

    // Randomized traffic with occasional flush, checked by the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16)
        fifo_q.push_back(DSIZE'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    run(20);

    // Reset mid-stream with buffered words.
    load_words(3, 8'hE0);
    out_ready = 1'b0;
    run(3);
    do_reset();
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
